boot_bus_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter that shares the single memory slave port between the SPI boot loader (M0) and the RISC-V core data port (M1).
- The boot-active flag (the loader's core_rst output) selects the policy. While boot is active, the loader has fixed priority and the core is stalled. After boot, the loader is locked out and the core owns the bus.
- Sits between the master ports and the memory slave.

---
 rtl/boot_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_boot_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_bus_arbiter.sv
// AHB-Lite arbiter sharing one memory slave between the SPI boot loader (M0) and the core data port (M1).
// Define ARB_M0_ERR_EN to answer masked loader transfers with a two-cycle ERROR instead of a silent OKAY.
module boot_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit GRANT_RST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_active,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic [DATA_W-1:0] m0_hrdata,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  input  logic [DATA_W-1:0] s_hrdata,
  output logic [15:0]       m0_drop_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2,
    OWN_DROP = 2'd3
  } own_e;

  logic        addrGnt_q, addrGnt_d;
  own_e        dataOwn_q, dataOwn_d;
  logic [15:0] dropCnt_q, dropCnt_d;

  logic m0Req, m1Req, m0Masked, gntMasked, gntReq, dropAcc;
  logic m0Erring, m0ErrReady;

  assign m0Req     = m0_htrans[1];
  assign m1Req     = m1_htrans[1];
  assign m0Masked  = ~boot_active;
  assign gntMasked = ~addrGnt_q & m0Masked;
  assign gntReq    = addrGnt_q ? m1Req : m0Req;

  // Every masked loader transfer that sees hready high has been accepted and must be counted.
  assign dropAcc     = ~reset & m0Masked & m0Req & m0_hready;
  assign m0_drop_cnt = dropCnt_q;

`ifdef ARB_M0_ERR_EN
  typedef enum logic [1:0] {
    ERR_IDLE   = 2'd0,
    ERR_FIRST  = 2'd1,
    ERR_SECOND = 2'd2
  } err_e;

  err_e err_q, err_d;

  always_comb begin
    err_d = ERR_IDLE;
    if (dropAcc)                 err_d = ERR_FIRST;
    else if (err_q == ERR_FIRST) err_d = ERR_SECOND;
  end

  assign m0Erring   = (err_q != ERR_IDLE);
  assign m0ErrReady = (err_q == ERR_SECOND);
`else
  assign m0Erring   = 1'b0;
  assign m0ErrReady = 1'b0;
`endif

  always_comb begin
    s_haddr  = addrGnt_q ? m1_haddr  : m0_haddr;
    s_hwrite = addrGnt_q ? m1_hwrite : m0_hwrite;
    s_hsize  = addrGnt_q ? m1_hsize  : m0_hsize;
    s_htrans = addrGnt_q ? m1_htrans : m0_htrans;
    if (reset || gntMasked) s_htrans = 2'b00;
    s_hwdata = (dataOwn_q == OWN_M1) ? m1_hwdata : m0_hwdata;
  end

  // Grant and data ownership only move on a cycle where the slave is ready.
  always_comb begin
    addrGnt_d = addrGnt_q;
    dataOwn_d = dataOwn_q;
    dropCnt_d = dropCnt_q;
    if (s_hready) begin
      if (!boot_active)  addrGnt_d = 1'b1;
      else if (m0Req)    addrGnt_d = 1'b0;
      else if (m1Req)    addrGnt_d = 1'b1;

      if (!gntReq)        dataOwn_d = OWN_NONE;
      else if (addrGnt_q) dataOwn_d = OWN_M1;
      else if (gntMasked) dataOwn_d = OWN_DROP;
      else                dataOwn_d = OWN_M0;
    end
    if (dropAcc && dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
  end

  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = 1'b0;
    m0_hrdata = '0;
    if (!reset) begin
      if (m0Erring) begin
        m0_hready = m0ErrReady;
        m0_hresp  = 1'b1;
      end else if (dataOwn_q == OWN_M0) begin
        m0_hready = s_hready;
        m0_hresp  = s_hresp;
        m0_hrdata = s_hrdata;
      end else if (!m0Masked && !addrGnt_q) begin
        m0_hready = s_hready;
      end else if (m0Req && !m0Masked) begin
        m0_hready = 1'b0;
      end
    end
  end

  always_comb begin
    m1_hready = 1'b1;
    m1_hresp  = 1'b0;
    m1_hrdata = '0;
    if (!reset) begin
      if (dataOwn_q == OWN_M1) begin
        m1_hready = s_hready;
        m1_hresp  = s_hresp;
        m1_hrdata = s_hrdata;
      end else if (addrGnt_q) begin
        m1_hready = s_hready;
      end else if (m1Req) begin
        m1_hready = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrGnt_q <= GRANT_RST;
      dataOwn_q <= OWN_NONE;
      dropCnt_q <= '0;
`ifdef ARB_M0_ERR_EN
      err_q     <= ERR_IDLE;
`endif
    end else begin
      addrGnt_q <= addrGnt_d;
      dataOwn_q <= dataOwn_d;
      dropCnt_q <= dropCnt_d;
`ifdef ARB_M0_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_boot_bus_arbiter.sv
// Randomized scoreboard bench for boot_bus_arbiter: two non-pipelined AHB masters, a wait/error slave,
// and a queue-based reference of what each accepted transfer must return and what the slave must see.
module tb_boot_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
`ifdef ARB_M0_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bootActive;
  logic [AW-1:0] mHaddr  [2];
  logic [1:0]    mHtrans [2];
  logic          mHwrite [2];
  logic [2:0]    mHsize  [2];
  logic [DW-1:0] mHwdata [2];
  logic          m0Hready, m0Hresp, m1Hready, m1Hresp;
  logic [DW-1:0] m0Hrdata, m1Hrdata;
  logic [AW-1:0] sHaddr;
  logic [1:0]    sHtrans;
  logic          sHwrite;
  logic [2:0]    sHsize;
  logic [DW-1:0] sHwdata;
  logic          sHready, sHresp;
  logic [DW-1:0] sHrdata;
  logic [15:0]   dropCnt;

  typedef struct { logic [DW-1:0] rdata; logic resp; } respT;
  typedef struct { logic [AW-1:0] addr; logic write; logic [2:0] size; logic [DW-1:0] wdata; } slvT;

  respT respQ0 [$];
  respT respQ1 [$];
  slvT  slaveQ [$];
  int   total = 0;
  int   bad = 0;
  int   dropModel = 0;
  bit   checking = 1'b1;

  boot_bus_arbiter dut (
    .clk(clk), .reset(reset), .boot_active(bootActive),
    .m0_haddr(mHaddr[0]), .m0_htrans(mHtrans[0]), .m0_hwrite(mHwrite[0]),
    .m0_hsize(mHsize[0]), .m0_hwdata(mHwdata[0]),
    .m0_hready(m0Hready), .m0_hresp(m0Hresp), .m0_hrdata(m0Hrdata),
    .m1_haddr(mHaddr[1]), .m1_htrans(mHtrans[1]), .m1_hwrite(mHwrite[1]),
    .m1_hsize(mHsize[1]), .m1_hwdata(mHwdata[1]),
    .m1_hready(m1Hready), .m1_hresp(m1Hresp), .m1_hrdata(m1Hrdata),
    .s_haddr(sHaddr), .s_htrans(sHtrans), .s_hwrite(sHwrite), .s_hsize(sHsize),
    .s_hwdata(sHwdata), .s_hready(sHready), .s_hresp(sHresp), .s_hrdata(sHrdata),
    .m0_drop_cnt(dropCnt)
  );

  always #5 clk = ~clk;

  // The slave's read data and error decision are pure functions of the address.
  function automatic logic [DW-1:0] slaveData(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic slaveErr(input logic [AW-1:0] a);
    return a[4:2] == 3'b111;
  endfunction

  function automatic logic hreadyOf(input int id);
    return (id == 0) ? m0Hready : m1Hready;
  endfunction

  function automatic logic hrespOf(input int id);
    return (id == 0) ? m0Hresp : m1Hresp;
  endfunction

  function automatic logic [DW-1:0] hrdataOf(input int id);
    return (id == 0) ? m0Hrdata : m1Hrdata;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for hready", name);
  endtask

  // One master issuing n single transfers; expectations are queued the moment a transfer is accepted.
  task automatic applyStimulus(input int id, input int n);
    for (int t = 0; t < n; t++) begin
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [2:0]    size;
      logic          wr;
      int            budget;
      respT          r;
      slvT           s;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      addr  = (AW'($urandom) & 32'h0000_0FFC) | ((id == 1) ? 32'h1000_0000 : 32'h0);
      wdata = DW'($urandom);
      size  = 3'($urandom_range(0, 2));
      wr    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mHaddr[id] = addr; mHtrans[id] = NONSEQ; mHwrite[id] = wr; mHsize[id] = size;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!hreadyOf(id) && budget < 400);
      if (!hreadyOf(id)) begin
        reportTimeout(id == 0 ? "m0_addr_phase" : "m1_addr_phase");
        mHtrans[id] = IDLE;
        return;
      end
      if (id == 0 && !bootActive) begin
        r.rdata = '0;
        r.resp  = DROP_ERR;
        if (dropModel < 65535) dropModel++;
      end else begin
        r.rdata = slaveData(addr);
        r.resp  = slaveErr(addr);
        s.addr = addr; s.write = wr; s.size = size; s.wdata = wdata;
        slaveQ.push_back(s);
      end
      if (id == 0) respQ0.push_back(r);
      else         respQ1.push_back(r);
      @(posedge clk); #1;
      mHtrans[id] = IDLE;
      mHwdata[id] = wdata;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!hreadyOf(id) && budget < 400);
      if (!hreadyOf(id)) begin
        reportTimeout(id == 0 ? "m0_data_phase" : "m1_data_phase");
        return;
      end
    end
  endtask

  // Slave with 0-2 random wait states and a two-cycle ERROR on selected addresses.
  initial begin : slaveModel
    bit            busy;
    bit            errNow;
    bit            errStage;
    int            waits;
    logic [AW-1:0] curAddr;
    logic          curWrite;
    logic [2:0]    curSize;
    slvT           e;
    busy = 1'b0; errNow = 1'b0; errStage = 1'b0; waits = 0;
    curAddr = '0; curWrite = 1'b0; curSize = '0;
    sHready = 1'b1; sHresp = 1'b0; sHrdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!busy) begin
        sHready = 1'b1; sHresp = 1'b0; sHrdata = DW'($urandom);
      end else if (waits > 0) begin
        sHready = 1'b0; sHresp = 1'b0; sHrdata = DW'($urandom);
      end else if (errNow && !errStage) begin
        sHready = 1'b0; sHresp = 1'b1; sHrdata = DW'($urandom);
      end else begin
        sHready = 1'b1; sHresp = errNow; sHrdata = slaveData(curAddr);
      end
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (sHready) begin
            busy = 1'b0;
            if (checking) begin
              if (slaveQ.size() == 0) begin
                checkOutput("slave_unexpected_xfer", curAddr, 32'hFFFF_FFFF);
              end else begin
                e = slaveQ.pop_front();
                checkOutput("slave_addr", curAddr, e.addr);
                checkOutput("slave_write", 32'(curWrite), 32'(e.write));
                checkOutput("slave_size", 32'(curSize), 32'(e.size));
                if (e.write) checkOutput("slave_wdata", sHwdata, e.wdata);
              end
            end
          end else if (waits > 0) begin
            waits--;
          end else begin
            errStage = 1'b1;
          end
        end
        if (sHready && sHtrans[1]) begin
          busy = 1'b1; curAddr = sHaddr; curWrite = sHwrite; curSize = sHsize;
          waits = int'($urandom_range(0, 2)); errNow = slaveErr(sHaddr); errStage = 1'b0;
        end
      end
    end
  end

  // Monitor: completes a master's data phase when its hready returns and compares against the queue.
  initial begin : monitor
    bit   pend [2];
    bit   prevErrWait [2];
    respT e;
    logic hr, rs;
    logic [DW-1:0] rd;
    pend[0] = 1'b0; pend[1] = 1'b0; prevErrWait[0] = 1'b0; prevErrWait[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !checking) begin
        pend[0] = 1'b0; pend[1] = 1'b0;
      end else begin
        for (int id = 0; id < 2; id++) begin
          hr = hreadyOf(id); rs = hrespOf(id); rd = hrdataOf(id);
          if (pend[id] && hr) begin
            pend[id] = 1'b0;
            if ((id == 0 && respQ0.size() == 0) || (id == 1 && respQ1.size() == 0)) begin
              checkOutput(id == 0 ? "m0_unexpected_resp" : "m1_unexpected_resp", rd, 32'hFFFF_FFFF);
            end else begin
              e = (id == 0) ? respQ0.pop_front() : respQ1.pop_front();
              checkOutput(id == 0 ? "m0_hresp" : "m1_hresp", 32'(rs), 32'(e.resp));
              if (e.resp)
                checkOutput(id == 0 ? "m0_err_first_cycle" : "m1_err_first_cycle",
                            32'(prevErrWait[id]), 32'd1);
              else
                checkOutput(id == 0 ? "m0_hrdata" : "m1_hrdata", rd, e.rdata);
            end
          end
          prevErrWait[id] = !hr && rs;
          if (mHtrans[id][1] && hr) pend[id] = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bootActive = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mHaddr[i] = '0; mHtrans[i] = IDLE; mHwrite[i] = 1'b0; mHsize[i] = 3'b010; mHwdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_s_htrans", 32'(sHtrans), 32'(IDLE));
    checkOutput("rst_m0_hready", 32'(m0Hready), 32'd1);
    checkOutput("rst_m1_hready", 32'(m1Hready), 32'd1);
    checkOutput("rst_m0_hresp", 32'(m0Hresp), 32'd0);
    checkOutput("rst_m1_hrdata", m1Hrdata, 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] boot phase with contention, boot_active falling mid-traffic");
    fork
      applyStimulus(0, 60);
      applyStimulus(1, 60);
      begin
        repeat ($urandom_range(150, 250)) @(posedge clk);
        #1 bootActive = 1'b0;
      end
    join

    $display("[TB] post-boot phase: loader masked, core owns the bus");
    fork
      applyStimulus(0, 8);
      applyStimulus(1, 20);
    join
    repeat (4) @(negedge clk);
    checkOutput("respq0_drained", 32'(respQ0.size()), 32'd0);
    checkOutput("respq1_drained", 32'(respQ1.size()), 32'd0);
    checkOutput("slaveq_drained", 32'(slaveQ.size()), 32'd0);
    checkOutput("drop_cnt", 32'(dropCnt), 32'(dropModel));

    $display("[TB] reset asserted mid-burst");
    checking = 1'b0;
    @(posedge clk); #1;
    bootActive = 1'b1;
    mHaddr[1] = 32'h1000_0100; mHtrans[1] = NONSEQ; mHwrite[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mHaddr[0] = 32'h0000_0040; mHtrans[0] = NONSEQ; mHwrite[0] = 1'b1;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_s_htrans", 32'(sHtrans), 32'(IDLE));
    checkOutput("midrst_m0_hready", 32'(m0Hready), 32'd1);
    checkOutput("midrst_m1_hready", 32'(m1Hready), 32'd1);
    checkOutput("midrst_m1_hresp", 32'(m1Hresp), 32'd0);
    checkOutput("midrst_drop_cnt", 32'(dropCnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postrst_s_haddr", sHaddr, 32'h0000_0040);
    checkOutput("postrst_s_htrans", 32'(sHtrans), 32'(NONSEQ));
    checkOutput("postrst_m1_hready", 32'(m1Hready), 32'd0);
    @(posedge clk); #1;
    mHtrans[0] = IDLE; mHtrans[1] = IDLE;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
